// File: rtl/spi_flash_responder.sv
// SPI flash read responder (mode 0, single-bit I/O).
// Accepts an 8-bit opcode and a 24-bit address over SPI. On the read opcode it
// fetches bytes from a backing memory and streams them MSB first on MISO. The
// address auto-increments while CS stays low. Any other opcode raises a
// one-clock error pulse, and the block stays silent until CS rises.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   i_SPI_CLK      SPI clock (asynchronous to clk, idle low)
//   i_SPI_CS       chip select, active low (asynchronous to clk)
//   i_SPI_MOSI     command/address in, MSB first
//   o_SPI_MISO     read data out, MSB first
//   o_MEM_ADDR     byte address to the backing memory
//   o_MEM_RD       one-clock read strobe; i_MEM_DATA is sampled on the next edge
//   i_MEM_DATA     memory read data
//   o_BUSY         transaction in progress
//   o_CMD_ERR      one-clock pulse on an unsupported opcode
//
// ADDR_WIDTH must lie in 2..24; only the low ADDR_WIDTH address bits are kept.
module spi_flash_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [7:0]  READ_CMD   = 8'h03
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_SPI_CLK,
  input  logic                  i_SPI_CS,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
  output logic                  o_MEM_RD,
  input  logic [7:0]            i_MEM_DATA,
  output logic                  o_BUSY,
  output logic                  o_CMD_ERR
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  state_t                  state;
  logic [4:0]              bit_cnt;
  logic [6:0]              cmd_sr;
  logic [ADDR_WIDTH-1:0]   addr_sr;
  logic [7:0]              tx_sr;
  logic                    rd_go;
  logic                    ld_pend;
  logic [1:0]              settle_cnt;
  logic                    armed;

  logic sck_p0, sck_p1, sck_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synchronized value for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_p0  <= 1'b0;
      sck_p1  <= 1'b0;
      sck_p2  <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sck_p0  <= i_SPI_CLK;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      cs_p0   <= i_SPI_CS;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      mosi_p0 <= i_SPI_MOSI;
      mosi_p1 <= mosi_p0;
    end
  end

  logic sck_rise, sck_fall, cs_fall;
  assign sck_rise = sck_p1 & ~sck_p2;
  assign sck_fall = ~sck_p1 & sck_p2;
  assign cs_fall  = ~cs_p1 & cs_p2;

  // The synchronizers reset to CS high, so a CS that is already low when reset
  // releases would look like a falling edge. Only accept a CS fall after CS has
  // really been seen high once the synchronizer has flushed its reset values.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'd2)
        settle_cnt <= settle_cnt + 2'd1;
      else if (cs_p1)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      addr_sr    <= '0;
      tx_sr      <= '0;
      rd_go      <= 1'b0;
      ld_pend    <= 1'b0;
      o_SPI_MISO <= 1'b0;
      o_MEM_ADDR <= '0;
      o_MEM_RD   <= 1'b0;
      o_BUSY     <= 1'b0;
      o_CMD_ERR  <= 1'b0;
    end else begin
      o_MEM_RD  <= 1'b0;
      o_CMD_ERR <= 1'b0;
      // CS high outranks any SCK activity seen in the same clock
      if (state != IDLE && cs_p1) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        rd_go      <= 1'b0;
        ld_pend    <= 1'b0;
        o_SPI_MISO <= 1'b0;
        o_BUSY     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            o_SPI_MISO <= 1'b0;
            if (armed && cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              o_BUSY  <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_sr <= {cmd_sr[5:0], mosi_p1};
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if ({cmd_sr, mosi_p1} == READ_CMD) begin
                  state <= ADDR;
                end else begin
                  state     <= IGNORE;
                  o_CMD_ERR <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            // After the 24th bit: strobe the read, then capture the data one clock later
            if (ld_pend) begin
              tx_sr   <= i_MEM_DATA;
              ld_pend <= 1'b0;
              state   <= DATA;
            end else if (rd_go) begin
              o_MEM_ADDR <= addr_sr;
              o_MEM_RD   <= 1'b1;
              rd_go      <= 1'b0;
              ld_pend    <= 1'b1;
            end else if (sck_rise) begin
              // Upper address bits fall off the top, leaving the low ADDR_WIDTH bits
              addr_sr <= {addr_sr[ADDR_WIDTH-2:0], mosi_p1};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                rd_go   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          DATA: begin
            if (ld_pend) begin
              tx_sr   <= i_MEM_DATA;
              ld_pend <= 1'b0;
            end else if (sck_fall) begin
              o_SPI_MISO <= tx_sr[7];
              tx_sr      <= {tx_sr[6:0], 1'b0};
            end
            // Prefetch on the 8th rise so the next MSB is loaded before the next fall
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt    <= '0;
                o_MEM_ADDR <= o_MEM_ADDR + ADDR_WIDTH'(1);
                o_MEM_RD   <= 1'b1;
                ld_pend    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          IGNORE: o_SPI_MISO <= 1'b0;
          default: begin
            state      <= IDLE;
            o_SPI_MISO <= 1'b0;
            o_BUSY     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized testbench for spi_flash_responder. A reference memory and the
// rule "byte i of a read from A is mem[(A+i) mod 2^16]" produce every expected
// value; a monitor counts read strobes, error pulses and MISO activity.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_SPI_CLK, i_SPI_CS, i_SPI_MOSI;
  logic        o_SPI_MISO;
  logic [15:0] o_MEM_ADDR;
  logic        o_MEM_RD;
  logic [7:0]  i_MEM_DATA;
  logic        o_BUSY, o_CMD_ERR;

  logic [7:0]  mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  int rd_cnt, err_cnt, err_wide, miso_ones, rd_snap;
  logic [31:0] rd_q [$];
  logic prev_err = 1'b0;

  spi_flash_responder #(.ADDR_WIDTH(16), .READ_CMD(8'h03)) dut (
    .clk(clk), .reset(reset),
    .i_SPI_CLK(i_SPI_CLK), .i_SPI_CS(i_SPI_CS), .i_SPI_MOSI(i_SPI_MOSI),
    .o_SPI_MISO(o_SPI_MISO), .o_MEM_ADDR(o_MEM_ADDR), .o_MEM_RD(o_MEM_RD),
    .i_MEM_DATA(i_MEM_DATA), .o_BUSY(o_BUSY), .o_CMD_ERR(o_CMD_ERR)
  );

  always #5 clk = ~clk;

  assign i_MEM_DATA = mem[o_MEM_ADDR];

  always @(negedge clk) begin
    if (o_MEM_RD) begin
      rd_cnt = rd_cnt + 1;
      rd_q.push_back({16'h0, o_MEM_ADDR});
    end
    if (o_CMD_ERR) err_cnt = err_cnt + 1;
    if (o_CMD_ERR && prev_err) err_wide = err_wide + 1;
    prev_err = o_CMD_ERR;
    if (o_SPI_MISO) miso_ones = miso_ones + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    rd_cnt = 0; err_cnt = 0; err_wide = 0; miso_ones = 0; rd_snap = 0;
    rd_q.delete();
  endtask

  task automatic cs_low();
    i_SPI_CS = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    i_SPI_CS = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    i_SPI_MOSI = b;
    tick(HALF);
    m = o_SPI_MISO;
    i_SPI_CLK = 1'b1;
    tick(HALF);
    i_SPI_CLK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit snap, output logic [7:0] m);
    logic bm;
    for (int i = 7; i >= 0; i--) begin
      if (snap && i == 0) rd_snap = rd_cnt;
      spi_bit(b[i], bm);
      m[i] = bm;
    end
  endtask

  task automatic read_txn(input logic [23:0] addr, input int n, input string tag);
    logic [7:0]  got;
    logic [15:0] a;
    clr_mon();
    cs_low();
    chk({tag, "_busy_hi"}, {31'h0, o_BUSY}, 32'h1);
    spi_byte(8'h03, 1'b0, got);
    spi_byte(addr[23:16], 1'b0, got);
    spi_byte(addr[15:8], 1'b0, got);
    spi_byte(addr[7:0], 1'b0, got);
    for (int i = 0; i < n; i++) begin
      a = addr[15:0] + 16'(i);
      spi_byte(8'($urandom()), (i == n - 1), got);
      chk({tag, "_byte"}, {24'h0, got}, {24'h0, mem[a]});
    end
    chk({tag, "_rd_count"}, rd_snap, n);
    for (int i = 0; i < n; i++) begin
      a = addr[15:0] + 16'(i);
      chk({tag, "_rd_addr"}, (rd_q.size() > i) ? rd_q[i] : 32'hDEAD_BEEF, {16'h0, a});
    end
    cs_high();
    chk({tag, "_rd_max"}, {31'h0, (rd_cnt <= n + 1)}, 32'h1);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_busy_lo"}, {31'h0, o_BUSY}, 32'h0);
    chk({tag, "_miso_idle"}, {31'h0, o_SPI_MISO}, 32'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  got;
    logic        bm;
    logic [23:0] addr24;
    int          nb;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom());
    clr_mon();

    reset = 1'b1; i_SPI_CLK = 1'b0; i_SPI_CS = 1'b1; i_SPI_MOSI = 1'b0;
    tick(3);
    chk("rst_miso", {31'h0, o_SPI_MISO}, 32'h0);
    chk("rst_rd",   {31'h0, o_MEM_RD},   32'h0);
    chk("rst_addr", {16'h0, o_MEM_ADDR}, 32'h0);
    chk("rst_busy", {31'h0, o_BUSY},     32'h0);
    chk("rst_err",  {31'h0, o_CMD_ERR},  32'h0);
    reset = 1'b0;
    tick(4);

    // Single byte at FFFD, then a 4-byte read wrapping through 0000
    mem[16'hFFFD] = 8'hA5;
    read_txn(24'h00FFFD, 1, "rd_a5");
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
    mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
    read_txn(24'h00FFFE, 4, "rd_wrap");

    // Unsupported opcode followed by 32 more clocks
    clr_mon();
    cs_low();
    spi_byte(8'h0B, 1'b0, got);
    for (int i = 0; i < 4; i++) spi_byte(8'($urandom()), 1'b0, got);
    chk("bad_err_cnt",  err_cnt,   1);
    chk("bad_err_wide", err_wide,  0);
    chk("bad_rd",       rd_cnt,    0);
    chk("bad_miso",     miso_ones, 0);
    chk("bad_busy_hi",  {31'h0, o_BUSY}, 32'h1);
    i_SPI_CS = 1'b1;
    tick(5);
    chk("bad_busy_lo",  {31'h0, o_BUSY}, 32'h0);
    tick(2 * HALF);

    // CS rises after 12 address bits, then a full read
    clr_mon();
    addr24 = 24'h001234;
    mem[16'h1234] = 8'h5A;
    cs_low();
    spi_byte(8'h03, 1'b0, got);
    for (int i = 23; i >= 12; i--) spi_bit(addr24[i], bm);
    cs_high();
    chk("abort_rd",   rd_cnt,    0);
    chk("abort_miso", miso_ones, 0);
    read_txn(24'h001234, 1, "after_abort");

    // Reset during bit 4 of the second data byte, SCK keeps going with CS low
    mem[16'h2000] = 8'hFF; mem[16'h2001] = 8'hFF; mem[16'h2002] = 8'hFF;
    cs_low();
    spi_byte(8'h03, 1'b0, got);
    spi_byte(8'h00, 1'b0, got);
    spi_byte(8'h20, 1'b0, got);
    spi_byte(8'h00, 1'b0, got);
    spi_byte(8'h00, 1'b0, got);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, bm);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    clr_mon();
    for (int i = 0; i < 20; i++) spi_bit(1'($urandom()), bm);
    chk("rst_mid_rd",   rd_cnt,    0);
    chk("rst_mid_miso", miso_ones, 0);
    chk("rst_mid_busy", {31'h0, o_BUSY}, 32'h0);
    cs_high();
    read_txn(24'h002000, 2, "after_rst");

    // Randomized reads, half of them placed near the wrap point
    for (int t = 0; t < 6; t++) begin
      addr24 = 24'($urandom());
      if ($urandom_range(0, 1) == 1) addr24[15:0] = 16'hFFFC + 16'($urandom_range(0, 3));
      nb = $urandom_range(1, 4);
      read_txn(addr24, nb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory address width; the low ADDR_WIDTH bits of the 24-bit SPI address are used.
REQ-002 Parameter READ_CMD, default 8'h03, opcode accepted as a read.
REQ-003 clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_SPI_CLK  input  1  SPI clock from the controller, mode 0 (idle low), asynchronous to clk.
REQ-006 i_SPI_CS  input  1  chip select, active low, asynchronous to clk.
REQ-007 i_SPI_MOSI  input  1  serial command/address, MSB first.
REQ-008 o_SPI_MISO  output  1  serial read data, MSB first.
REQ-009 o_MEM_ADDR  output  ADDR_WIDTH  byte address to backing memory.
REQ-010 o_MEM_RD  output  1  one-clk read strobe; i_MEM_DATA is valid on the clk edge after the strobe.
REQ-011 i_MEM_DATA  input  8  read data from backing memory.
REQ-012 o_BUSY  output  1  high while CS is low and the FSM is not IDLE.
REQ-013 o_CMD_ERR  output  1  one-clk pulse when an unsupported opcode is received.

Function
REQ-014 i_SPI_CLK, i_SPI_CS and i_SPI_MOSI SHALL each pass through a 2-flop synchronizer; edges are detected on synchronized SCK (rise = sample, fall = drive).
REQ-015 Supported SCK frequency SHALL be at most clk/8; SCK high and low times SHALL each be at least 4 clk periods.
REQ-016 States SHALL be IDLE, CMD, ADDR, DATA, IGNORE.
REQ-017 IDLE -> CMD on synchronized CS falling; bit counter cleared.
REQ-018 CMD: shift MOSI on 8 SCK rises; after the 8th, if the opcode equals READ_CMD go to ADDR, else go to IGNORE and pulse o_CMD_ERR for exactly 1 clk.
REQ-019 ADDR: shift 24 address bits on SCK rises; one clk after the 24th rise, drive o_MEM_ADDR = addr[ADDR_WIDTH-1:0], pulse o_MEM_RD, load i_MEM_DATA into the TX shift register the following clk, and enter DATA.
REQ-020 DATA: on the first SCK fall after entry, o_SPI_MISO SHALL take TX bit 7; each later fall shifts out the next bit.
REQ-021 On the SCK rise of bit 8 of each data byte, the address SHALL increment by 1 (modulo 2^ADDR_WIDTH, 0xFFFF -> 0x0000) and a prefetch (o_MEM_RD pulse) SHALL be issued, so the next byte's MSB is loaded before the next SCK fall.
REQ-022 Reads SHALL continue indefinitely while CS stays low.
REQ-023 IGNORE: no memory reads, o_SPI_MISO = 0, until CS rises.
REQ-024 Synchronized CS rising in any state SHALL force IDLE on the next clk, clear counters, drive o_SPI_MISO = 0; a partial byte or address is discarded.
REQ-025 CS falling and rising in the same synchronized sample window are impossible by construction; CS high always has priority over SCK edges in the same clk.
REQ-026 o_SPI_MISO SHALL be 0 in every state except DATA.
REQ-027 At most one o_MEM_RD pulse per data byte; none outside ADDR->DATA transition and DATA prefetch.

Reset
REQ-028 On reset: state IDLE, o_SPI_MISO 0, o_MEM_RD 0, o_MEM_ADDR 0, o_BUSY 0, o_CMD_ERR 0, shift registers and counters 0, synchronizers loaded with idle values (SCK 0, CS 1, MOSI 0).
REQ-029 Reset asserted mid-transaction SHALL abort it; after reset release the block SHALL ignore bus activity until a fresh CS falling edge.

Verification
REQ-030 Reset held 3 clks, CS high -> all outputs 0, state IDLE.
REQ-031 CS low, opcode 0x03, address 0x00FFFD, memory[0xFFFD]=0xA5, 8 data clocks -> o_MEM_ADDR 0xFFFD, one o_MEM_RD, MISO bits 1,0,1,0,0,1,0,1.
REQ-032 Read from 0x00FFFE for 4 bytes, memory FFFE=0x11, FFFF=0x22, 0000=0x33, 0001=0x44 -> MISO bytes 11,22,33,44; o_MEM_ADDR sequence FFFE, FFFF, 0000, 0001.
REQ-033 Opcode 0x0B then 32 more SCK cycles -> single 1-clk o_CMD_ERR pulse, zero o_MEM_RD pulses, MISO constant 0, o_BUSY low one clk after CS rise.
REQ-034 CS rises after 12 address bits, then a full read of 0x001234 (memory=0x5A) -> first transaction yields no o_MEM_RD; second yields MISO 0x5A.
REQ-035 Reset asserted during bit 4 of a data byte, SCK continuing with CS low -> MISO 0 and no o_MEM_RD until CS cycles high then low and a new command is sent.
